mux_sel_ctrl: RTL and testbench
===============================

MUX_SEL_CTRL -- requirements
Module: mux_sel_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 500000, consecutive stable clocks before a button level is accepted (min 2).
REQ-002 Parameter SCAN_PERIOD, default 50000000, clocks between select advances in scan mode (min 2).
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 btnl  input  1  raw button; step select down (manual mode).
REQ-006 btnr  input  1  raw button; step select up (manual mode).
REQ-007 btnu  input  1  raw button; enter scan mode.
REQ-008 btnd  input  1  raw button; leave scan mode.
REQ-009 btnc  input  1  raw button; toggle datapath enable.
REQ-010 sel  output  4  select driven to the mux/demux datapath.
REQ-011 en  output  1  datapath enable; datapath output forced 0 when low.
REQ-012 mode  output  2  current state: 00 OFF, 01 MANUAL, 10 SCAN.
REQ-013 upd  output  1  one-clock strobe on any cycle sel or en changes.

Function
REQ-014 Each button: 2-flop synchronizer, then debouncer; debounced level changes only after synchronized input holds the new value DB_CYCLES consecutive clocks; counter restarts on any bounce.
REQ-015 Press event = one-clock pulse on debounced 0->1 edge; release generates no event; held button generates exactly one event.
REQ-016 Latency: input stable high from edge 0 -> resulting sel/en/mode change visible after edge DB_CYCLES+3, no later.
REQ-017 States OFF, MANUAL, SCAN; en=1 in MANUAL and SCAN, 0 in OFF; mode encodes state.
REQ-018 btnc event: OFF->MANUAL; MANUAL->OFF; SCAN->OFF; btnc has highest priority over all other same-cycle events.
REQ-019 btnu event in MANUAL -> SCAN, scan timer cleared; ignored in OFF and SCAN.
REQ-020 btnd event in SCAN -> MANUAL, sel held at current value; ignored in OFF and MANUAL.
REQ-021 MANUAL: btnr event sel=sel+1 mod 16 (15->0); btnl event sel=sel-1 mod 16 (0->15); both in same cycle -> no change.
REQ-022 SCAN: timer counts 0..SCAN_PERIOD-1; on terminal count sel=sel+1 mod 16 and timer -> 0; btnl/btnr ignored.
REQ-023 OFF: sel retained (not cleared); btnl/btnr/btnu/btnd ignored; re-entering MANUAL resumes previous sel.
REQ-024 Same-cycle btnu and btnr in MANUAL: transition to SCAN and step sel by +1 both take effect.
REQ-025 upd asserted the cycle after the register update, exactly one clock per change; not asserted when value unchanged (e.g. l+r together).

Reset
REQ-026 rst_n low asynchronously forces: state OFF, sel=0, en=0, mode=00, upd=0, scan timer 0, all debouncer levels 0 and counters 0, synchronizers 0.
REQ-027 Reset mid-scan or mid-debounce discards pending events; a button held through reset release must produce one event only after full debounce (level starts 0).
REQ-028 No output changes in the first clock after rst_n deasserts.

Verification (DB_CYCLES=4, SCAN_PERIOD=8)
REQ-029 Reset, btnc pulse 10 clocks -> en=1, mode=01, sel=0, upd one pulse, at edge 7.
REQ-030 MANUAL, sel=0, btnl pressed -> sel=15; then btnr twice -> sel=1; btnl+btnr together -> sel stays 1, no upd.
REQ-031 btnc bounce 1-0-1-0 per clock then stable high 10 clocks -> exactly one toggle.
REQ-032 MANUAL sel=14, btnu press -> mode=10; sel 15 after 8 clocks, 0 after 16, 1 after 24; btnd -> mode=01, sel frozen.
REQ-033 SCAN, btnc and btnd pressed same cycle -> mode=00, en=0; later btnc -> MANUAL with retained sel.
REQ-034 rst_n pulsed low mid-scan with btnr held -> all outputs 0 immediately; btnr still held -> no event until released and re-pressed.

Source files
------------

// File: rtl/mux_sel_ctrl.sv
// Button-driven select controller: synchronise, debounce and edge-detect five buttons, then run OFF/MANUAL/SCAN.
// A clean press is visible on sel/en/mode DB_CYCLES+3 clocks after it starts; upd strobes with each sel/en change.
module mux_sel_ctrl #(
   parameter int DB_CYCLES   = 500000,
   parameter int SCAN_PERIOD = 50000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btnl,
   input  logic       btnr,
   input  logic       btnu,
   input  logic       btnd,
   input  logic       btnc,
   output logic [3:0] sel,
   output logic       en,
   output logic [1:0] mode,
   output logic       upd
);

   localparam int DBW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
   localparam int SPW = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD) : 1;
   localparam logic [DBW-1:0] DB_MAX = DBW'(DB_CYCLES - 1);
   localparam logic [SPW-1:0] SP_MAX = SPW'(SCAN_PERIOD - 1);

   localparam logic [1:0] ST_OFF  = 2'b00;
   localparam logic [1:0] ST_MAN  = 2'b01;
   localparam logic [1:0] ST_SCAN = 2'b10;

   localparam int IL = 0;
   localparam int IR = 1;
   localparam int IU = 2;
   localparam int ID = 3;
   localparam int IC = 4;

   logic [4:0]     raw, s1, s2, lvl, lvl_q, ev;
   logic [DBW-1:0] cnt [5];
   logic [1:0]     state, state_n;
   logic [3:0]     sel_n;
   logic           en_n;
   logic [SPW-1:0] tmr, tmr_n;

   assign raw  = {btnc, btnd, btnu, btnr, btnl};
   assign mode = state;

   // Any sample that disagrees with the settled level counts; an agreeing sample restarts the run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1    <= '0;
         s2    <= '0;
         lvl   <= '0;
         lvl_q <= '0;
         ev    <= '0;
         for (int i = 0; i < 5; i++) cnt[i] <= '0;
      end else begin
         s1    <= raw;
         s2    <= s1;
         lvl_q <= lvl;
         ev    <= lvl & ~lvl_q;
         for (int i = 0; i < 5; i++) begin
            if (s2[i] == lvl[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DB_MAX) begin
               lvl[i] <= s2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_n = state;
      sel_n   = sel;
      tmr_n   = tmr;
      if (ev[IC]) begin
         state_n = (state == ST_OFF) ? ST_MAN : ST_OFF;
         tmr_n   = '0;
      end else begin
         case (state)
            ST_MAN: begin
               if (ev[IR] && !ev[IL])      sel_n = sel + 4'd1;
               else if (ev[IL] && !ev[IR]) sel_n = sel - 4'd1;
               if (ev[IU]) begin
                  state_n = ST_SCAN;
                  tmr_n   = '0;
               end
            end
            ST_SCAN: begin
               // Leaving scan wins over a coincident terminal count so sel freezes where the user saw it.
               if (ev[ID]) begin
                  state_n = ST_MAN;
                  tmr_n   = '0;
               end else if (tmr == SP_MAX) begin
                  sel_n = sel + 4'd1;
                  tmr_n = '0;
               end else begin
                  tmr_n = tmr + 1'b1;
               end
            end
            default: ;
         endcase
      end
      en_n = (state_n != ST_OFF);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_OFF;
         sel   <= '0;
         en    <= 1'b0;
         tmr   <= '0;
         upd   <= 1'b0;
      end else begin
         state <= state_n;
         sel   <= sel_n;
         en    <= en_n;
         tmr   <= tmr_n;
         upd   <= (sel_n != sel) || (en_n != en);
      end
   end

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Scoreboarded bench for mux_sel_ctrl: a behavioural model predicts every output change and its cycle.
module tb_mux_sel_ctrl;

   localparam int DB = 4;
   localparam int SP = 8;

   localparam logic [4:0] BL = 5'b00001;
   localparam logic [4:0] BR = 5'b00010;
   localparam logic [4:0] BU = 5'b00100;
   localparam logic [4:0] BD = 5'b01000;
   localparam logic [4:0] BC = 5'b10000;

   localparam int OFF = 0;
   localparam int MAN = 1;
   localparam int SCN = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] btn = '0;
   logic [3:0] sel;
   logic       en;
   logic [1:0] mode;
   logic       upd;

   mux_sel_ctrl #(.DB_CYCLES(DB), .SCAN_PERIOD(SP)) dut (
      .clk(clk), .rst_n(rst_n),
      .btnl(btn[0]), .btnr(btn[1]), .btnu(btn[2]), .btnd(btn[3]), .btnc(btn[4]),
      .sel(sel), .en(en), .mode(mode), .upd(upd)
   );

   always #5 clk = ~clk;

   typedef struct {int cyc; int sel; int en; int mode; int upd;} exp_t;
   exp_t q[$];

   int n_chk = 0;
   int n_fail = 0;
   int upd_cnt = 0;
   int cyc = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: a level flips once the last DB synchronised samples all disagree with it;
   // a rising flip acts on the controller two clocks later.
   bit hist [5][0:DB];
   int mlvl [5];
   int p0 [5];
   int p1 [5];
   int m_state = OFF;
   int m_sel = 0;
   int m_tmr = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state = OFF; m_sel = 0; m_tmr = 0;
         for (int b = 0; b < 5; b++) begin
            mlvl[b] = 0; p0[b] = 0; p1[b] = 0;
            for (int j = 0; j <= DB; j++) hist[b][j] = 1'b0;
         end
         q.delete();
      end else begin
         int ev [5];
         int o_sel, o_en, o_mode, n_en;
         bit flip;
         cyc++;
         o_sel = m_sel; o_en = (m_state != OFF) ? 1 : 0; o_mode = m_state;
         for (int b = 0; b < 5; b++) begin
            ev[b] = p1[b];
            p1[b] = p0[b];
            flip = 1'b1;
            for (int j = 0; j < DB; j++) if (int'(hist[b][j]) == mlvl[b]) flip = 1'b0;
            p0[b] = 0;
            if (flip) begin
               mlvl[b] = 1 - mlvl[b];
               p0[b] = mlvl[b];
            end
            for (int j = 0; j < DB; j++) hist[b][j] = hist[b][j+1];
            hist[b][DB] = btn[b];
         end
         if (ev[4] != 0) begin
            m_state = (m_state == OFF) ? MAN : OFF;
            m_tmr = 0;
         end else if (m_state == MAN) begin
            m_sel = (m_sel + ev[1] - ev[0] + 16) % 16;
            if (ev[2] != 0) begin m_state = SCN; m_tmr = 0; end
         end else if (m_state == SCN) begin
            if (ev[3] != 0) begin m_state = MAN; m_tmr = 0; end
            else if (m_tmr == SP - 1) begin m_sel = (m_sel + 1) % 16; m_tmr = 0; end
            else m_tmr++;
         end
         n_en = (m_state != OFF) ? 1 : 0;
         if (m_sel != o_sel || n_en != o_en || m_state != o_mode)
            q.push_back('{cyc, m_sel, n_en, m_state,
                          (m_sel != o_sel || n_en != o_en) ? 1 : 0});
      end
   end

   // Monitor: pops one expectation whenever the DUT strobes upd or changes mode.
   int prev_mode = 0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (upd || int'(mode) != prev_mode) begin
            if (q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_change: sel=%0d en=%0d mode=%0d upd=%0d, expected no change (cycle %0d)",
                        sel, en, mode, upd, cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("change_cycle", cyc, e.cyc);
               check("sb_sel", int'(sel), e.sel);
               check("sb_en", int'(en), e.en);
               check("sb_mode", int'(mode), e.mode);
               check("sb_upd", int'(upd), e.upd);
            end
         end
         if (q.size() > 0 && q[0].cyc < cyc) begin
            exp_t e;
            e = q.pop_front();
            n_chk++; n_fail++;
            $display("FAIL missed_change: no output change seen, expected sel=%0d en=%0d mode=%0d at cycle %0d",
                     e.sel, e.en, e.mode, e.cyc);
         end
         if (upd) upd_cnt++;
      end
      prev_mode = int'(mode);
   end

   task automatic hold(input logic [4:0] b, input int n);
      @(negedge clk);
      btn = b;
      repeat (n) @(posedge clk);
   endtask

   task automatic press(input logic [4:0] b);
      hold(b, 10);
      hold('0, 12);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      int u0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_sel", int'(sel), 0);
      check("rst_en", int'(en), 0);
      check("rst_mode", int'(mode), 0);
      check("rst_upd", int'(upd), 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_en", int'(en), 0);
      check("post_rst_upd", int'(upd), 0);

      // Power on: change lands exactly on edge DB+3
      @(negedge clk);
      btn = BC;
      repeat (7) @(posedge clk);
      #1 check("on_early_en", int'(en), 0);
      @(posedge clk); #1;
      check("on_en", int'(en), 1);
      check("on_mode", int'(mode), MAN);
      check("on_sel", int'(sel), 0);
      check("on_upd", int'(upd), 1);
      @(posedge clk); #1;
      check("on_upd_pulse", int'(upd), 0);
      hold('0, 12);

      // Manual stepping with wrap, and l+r cancelling
      press(BL);
      check("wrap_down", int'(sel), 15);
      press(BR);
      press(BR);
      check("wrap_up", int'(sel), 1);
      u0 = upd_cnt;
      press(BL | BR);
      check("lr_sel", int'(sel), 1);
      check("lr_no_upd", upd_cnt - u0, 0);

      // Bouncing btnc toggles once
      u0 = upd_cnt;
      hold(BC, 1); hold('0, 1); hold(BC, 1); hold('0, 1);
      hold(BC, 10); hold('0, 12);
      check("bounce_mode", int'(mode), OFF);
      check("bounce_one_toggle", upd_cnt - u0, 1);
      press(BC);
      check("resume_sel", int'(sel), 1);
      press(BL); press(BL); press(BL);
      check("sel14", int'(sel), 14);

      // Scan: steps every SP clocks, exit coincides with a terminal count
      @(negedge clk);
      btn = BU;
      repeat (8) @(posedge clk);
      #1 check("scan_mode", int'(mode), SCN);
      check("scan_sel0", int'(sel), 14);
      repeat (8) @(posedge clk);
      #1 check("scan_sel1", int'(sel), 15);
      repeat (8) @(posedge clk);
      #1 check("scan_sel2", int'(sel), 0);
      repeat (8) @(posedge clk);
      #1 check("scan_sel3", int'(sel), 1);
      hold(BD, 10); hold('0, 12);
      check("scan_exit_mode", int'(mode), MAN);
      check("scan_exit_sel", int'(sel), 1);

      // btnc beats btnd; sel retained through OFF
      press(BU);
      hold(BC | BD, 10); hold('0, 12);
      check("cd_mode", int'(mode), OFF);
      check("cd_en", int'(en), 0);
      press(BC);
      check("cd_resume_mode", int'(mode), MAN);
      check("cd_resume_sel", int'(sel), m_sel);

      // Reset mid-scan with btnr held
      press(BU);
      hold(BR, 5);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_sel", int'(sel), 0);
      check("arst_en", int'(en), 0);
      check("arst_mode", int'(mode), 0);
      check("arst_upd", int'(upd), 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      check("arst_first_clk_sel", int'(sel), 0);
      check("arst_first_clk_mode", int'(mode), 0);
      hold(BR, 15);
      check("held_r_off", int'(mode), OFF);
      hold(BR | BC, 10); hold(BR, 12);
      check("held_r_mode", int'(mode), MAN);
      check("held_r_sel", int'(sel), 0);
      hold('0, 12);
      press(BR);
      check("repress_r_sel", int'(sel), 1);

      // Random stimulus, short holds act as bounces
      for (int it = 0; it < 120; it++) begin
         if ($urandom_range(0, 24) == 0) begin
            pulse_reset();
         end else begin
            hold(5'($urandom_range(1, 31)), $urandom_range(1, 12));
            hold('0, $urandom_range(0, 14));
         end
      end
      hold('0, 20);
      check("drain_queue", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
